uart_debugger: RTL and testbench

- Debug/telemetry block on the root clock.
- Periodically snapshots a wide status vector and streams it as bytes over a UART TX line (8N1).
- Simultaneously receives single-byte commands on a UART RX line and presents each as a byte plus a one-cycle strobe.
- Other blocks use the strobe, for example to trigger a soft reset on the 'H' command.

---
 rtl/uart_debug_pkg.sv | 23 ++
 rtl/uart_debugger_byte_tx.sv | 96 +++++++++
 rtl/uart_debugger.sv | 197 +++++++++++++++++++
 tb/tb_uart_debugger.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_debug_pkg.sv
// Shared UART framing constants and state encodings for the debug UART
// transmitter and receiver.
package uart_debug_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_debugger_byte_tx.sv
// 8N1 byte transmitter. busy_out drops in the final stop-bit cycle so a new
// start strobe chains the next byte with no idle gap on the line.
module uart_byte_tx
    import uart_debug_pkg::*;
#(
    parameter int UART_TICKS_PER_BIT      = 139,
    parameter int UART_TICKS_PER_BIT_SIZE = 8
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       start_in,
    output logic       busy_out,
    output logic       tx_out
);

    localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] BIT_LAST =
        UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

    tx_state_t                          state_q, state_d;
    logic [UART_TICKS_PER_BIT_SIZE-1:0] cnt_q, cnt_d;
    logic [2:0]                         bit_q, bit_d;
    logic [7:0]                         shreg_q, shreg_d;
    logic                               tx_q, tx_d;
    logic                               bit_end;
    logic                               ready;

    assign bit_end  = (cnt_q == BIT_LAST);
    assign ready    = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
    assign busy_out = !ready;
    assign tx_out   = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: cnt_d = '0;
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_d = TX_STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                    tx_d    = STOP_BIT;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (ready && start_in) begin
            state_d = TX_START;
            cnt_d   = '0;
            tx_d    = START_BIT;
            shreg_d = byte_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk_in) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/uart_debugger.sv
// Debug UART: periodically streams a snapshot of data_in MSB-byte first over
// tx_out and receives single-byte commands on debug_uart_rx_in.
module uart_debugger
    import uart_debug_pkg::*;
#(
    parameter int DIVIDER_TICKS_WIDTH     = 20,
    parameter int DIVIDER_TICKS           = 727273,
    parameter int DATA_WIDTH_BASE2        = 8,
    parameter int DATA_WIDTH              = 192,
    parameter int UART_TICKS_PER_BIT      = 139,
    parameter int UART_TICKS_PER_BIT_SIZE = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  debug_uart_rx_in,
    output logic [7:0]            debug_command,
    output logic                  debug_command_pulse,
    output logic                  debug_command_busy,
    output logic                  tx_out
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [DIVIDER_TICKS_WIDTH-1:0] PERIOD_LAST =
        DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
    localparam logic [DATA_WIDTH_BASE2-1:0] BYTES_AFTER_FIRST =
        DATA_WIDTH_BASE2'(NUM_BYTES - 1);
    localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] BIT_LAST =
        UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1);
    localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] HALF_LAST =
        UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT / 2 - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

    logic [DIVIDER_TICKS_WIDTH-1:0] period_q, period_d;
    logic                           tick;
    logic                           frame_active_q, frame_active_d;
    logic [DATA_WIDTH_BASE2-1:0]    bytes_left_q, bytes_left_d;
    logic [DATA_WIDTH-1:0]          shadow_q, shadow_d;
    logic [7:0]                     tx_byte;
    logic                           tx_start;
    logic                           tx_busy;

    assign tick = (period_q == PERIOD_LAST);

    // The shadow is a left-shifting queue: its top byte is always the next one to send.
    always_comb begin
        period_d       = tick ? '0 : period_q + 1'b1;
        frame_active_d = frame_active_q;
        bytes_left_d   = bytes_left_q;
        shadow_d       = shadow_q;
        tx_byte        = shadow_q[DATA_WIDTH-1 -: 8];
        tx_start       = 1'b0;
        if (!frame_active_q) begin
            if (tick) begin
                frame_active_d = 1'b1;
                tx_start       = 1'b1;
                tx_byte        = data_in[DATA_WIDTH-1 -: 8];
                shadow_d       = data_in << 8;
                bytes_left_d   = BYTES_AFTER_FIRST;
            end
        end else if (!tx_busy) begin
            if (bytes_left_q == '0) begin
                frame_active_d = 1'b0;
            end else begin
                tx_start     = 1'b1;
                shadow_d     = shadow_q << 8;
                bytes_left_d = bytes_left_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            period_q       <= '0;
            frame_active_q <= 1'b0;
            bytes_left_q   <= '0;
        end else begin
            period_q       <= period_d;
            frame_active_q <= frame_active_d;
            bytes_left_q   <= bytes_left_d;
        end
    end

    always_ff @(posedge clk_in) begin
        shadow_q <= shadow_d;
    end

    uart_byte_tx #(
        .UART_TICKS_PER_BIT      (UART_TICKS_PER_BIT),
        .UART_TICKS_PER_BIT_SIZE (UART_TICKS_PER_BIT_SIZE)
    ) u_byte_tx (
        .clk_in   (clk_in),
        .reset    (reset),
        .byte_in  (tx_byte),
        .start_in (tx_start),
        .busy_out (tx_busy),
        .tx_out   (tx_out)
    );

    logic                               rx_meta_q, rx_sync_q;
    rx_state_t                          rx_state_q, rx_state_d;
    logic [UART_TICKS_PER_BIT_SIZE-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]                         rx_bit_q, rx_bit_d;
    logic [7:0]                         rx_shreg_q, rx_shreg_d;
    logic [7:0]                         cmd_q, cmd_d;
    logic                               pulse_q, pulse_d;
    logic                               busy_q, busy_d;

    // Samples land mid-bit: half a bit after the start edge, then every full bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shreg_d = rx_shreg_q;
        cmd_d      = cmd_q;
        pulse_d    = 1'b0;
        busy_d     = busy_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_sync_q == START_BIT) begin
                    rx_state_d = RX_START;
                    busy_d     = 1'b1;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q == START_BIT) begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                    end else begin
                        rx_state_d = RX_IDLE;
                        busy_d     = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    busy_d     = 1'b0;
                    if (rx_sync_q == STOP_BIT) begin
                        cmd_d   = rx_shreg_q;
                        pulse_d = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rx_meta_q  <= STOP_BIT;
            rx_sync_q  <= STOP_BIT;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            cmd_q      <= 8'h00;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q  <= debug_uart_rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            cmd_q      <= cmd_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk_in) begin
        rx_shreg_q <= rx_shreg_d;
    end

    assign debug_command       = cmd_q;
    assign debug_command_pulse = pulse_q;
    assign debug_command_busy  = busy_q;

endmodule

// File: tb/tb_uart_debugger.sv
// Directed bench for uart_debugger with 16-bit data and 4 clocks per UART bit;
// a second instance with a 50-clock period exercises dropped ticks.
`timescale 1ns/1ps
module tb_uart_debugger;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_a = 16'h0000;
    logic        rx_line = 1'b1;
    logic [7:0]  cmd_a;
    logic        pulse_a, busy_a, tx_a;
    logic [7:0]  cmd_b;
    logic        pulse_b, busy_b, tx_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    int rel_cyc = 0;

    typedef struct {
        logic [15:0] d_pre;
        logic [15:0] d_mid;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } tx_vec_t;

    typedef struct {
        logic [7:0] byte_v;
        logic       stop;
        logic [7:0] exp_cmd;
        int         exp_pulses;
    } rx_vec_t;

    tx_vec_t tx_tab [4];
    rx_vec_t rx_tab [6];

    uart_debugger #(
        .DIVIDER_TICKS_WIDTH(20), .DIVIDER_TICKS(200), .DATA_WIDTH_BASE2(8),
        .DATA_WIDTH(16), .UART_TICKS_PER_BIT(T), .UART_TICKS_PER_BIT_SIZE(8)
    ) dut (
        .clk_in(clk), .reset(reset), .data_in(data_a), .debug_uart_rx_in(rx_line),
        .debug_command(cmd_a), .debug_command_pulse(pulse_a),
        .debug_command_busy(busy_a), .tx_out(tx_a)
    );

    uart_debugger #(
        .DIVIDER_TICKS_WIDTH(20), .DIVIDER_TICKS(50), .DATA_WIDTH_BASE2(8),
        .DATA_WIDTH(16), .UART_TICKS_PER_BIT(T), .UART_TICKS_PER_BIT_SIZE(8)
    ) dut_b (
        .clk_in(clk), .reset(reset), .data_in(16'hC33C), .debug_uart_rx_in(1'b1),
        .debug_command(cmd_b), .debug_command_pulse(pulse_b),
        .debug_command_busy(busy_b), .tx_out(tx_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (pulse_a === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_cyc <= cyc;
        end
    end

    function automatic logic txsel(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Samples the current point, then one per falling edge, until the line goes low.
    task automatic wait_start(input bit sel, input int exp_cyc, input string name);
        int n;
        n = 0;
        while (txsel(sel) !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, cyc, exp_cyc);
    endtask

    task automatic check_byte(input bit sel, input logic [7:0] exp, input string name);
        logic [9:0] want;
        logic [9:0] seen;
        int bad;
        want = {1'b1, exp, 1'b0};
        seen = '0;
        bad  = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < T; j++) begin
                if (txsel(sel) !== want[k]) bad++;
                if (j == T / 2) seen[k] = txsel(sel);
                @(negedge clk);
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: line bits %b with %0d wrong samples, required %b",
                     name, seen, bad, want);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              output int s_cyc, output logic busy_mid);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        busy_mid = 1'b0;
        @(posedge clk);
        #1;
        s_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            rx_line = bits[k];
            repeat (T) @(posedge clk);
            #1;
            if (k == 5) busy_mid = busy_a;
        end
        rx_line = 1'b1;
    endtask

    initial begin
        int s, p0, n, r2;
        logic bm;

        tx_tab[0] = '{16'hA55A, 16'h1234, 8'hA5, 8'h5A};
        tx_tab[1] = '{16'h1234, 16'h1234, 8'h12, 8'h34};
        tx_tab[2] = '{16'h00FF, 16'hFF00, 8'h00, 8'hFF};
        tx_tab[3] = '{16'h8001, 16'h0000, 8'h80, 8'h01};

        rx_tab[0] = '{8'h48, 1'b1, 8'h48, 1};
        rx_tab[1] = '{8'hA7, 1'b1, 8'hA7, 1};
        rx_tab[2] = '{8'h3C, 1'b0, 8'hA7, 0};
        rx_tab[3] = '{8'h00, 1'b1, 8'h00, 1};
        rx_tab[4] = '{8'hFF, 1'b1, 8'hFF, 1};
        rx_tab[5] = '{8'h81, 1'b0, 8'hFF, 0};

        data_a = tx_tab[0].d_pre;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_tx", tx_a, 1);
        chk("reset_cmd", cmd_a, 8'h00);
        chk("reset_pulse", pulse_a, 0);
        chk("reset_busy", busy_a, 0);
        reset = 1'b0;
        rel_cyc = cyc;

        // ---- Snapshot frames and dropped ticks, run side by side ----
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    data_a = tx_tab[i].d_pre;
                    wait_start(1'b0, rel_cyc + 200 * (i + 1), $sformatf("a_start%0d", i));
                    check_byte(1'b0, tx_tab[i].b0, $sformatf("a_byte0_%0d", i));
                    data_a = tx_tab[i].d_mid;
                    check_byte(1'b0, tx_tab[i].b1, $sformatf("a_byte1_%0d", i));
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    wait_start(1'b1, rel_cyc + 50 + 100 * i, $sformatf("b_start%0d", i));
                    check_byte(1'b1, 8'hC3, $sformatf("b_byte0_%0d", i));
                    check_byte(1'b1, 8'h3C, $sformatf("b_byte1_%0d", i));
                end
            end
        join

        // ---- Command reception, including framing errors ----
        for (int i = 0; i < 6; i++) begin
            p0 = pulse_cnt;
            send_frame(rx_tab[i].byte_v, rx_tab[i].stop, s, bm);
            repeat (10) @(posedge clk);
            #1;
            chk($sformatf("rx_cmd%0d", i), cmd_a, rx_tab[i].exp_cmd);
            chk($sformatf("rx_pulses%0d", i), pulse_cnt - p0, rx_tab[i].exp_pulses);
            chk($sformatf("rx_busy_mid%0d", i), bm, 1);
            chk($sformatf("rx_busy_end%0d", i), busy_a, 0);
            if (rx_tab[i].exp_pulses == 1)
                chk($sformatf("rx_latency_ok%0d", i),
                    ((pulse_cyc - s) >= 38 && (pulse_cyc - s) <= 42) ? 1 : 0, 1);
        end

        // ---- One-clock glitch on RX ----
        p0 = pulse_cnt;
        @(posedge clk);
        #1;
        rx_line = 1'b0;
        @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("glitch_busy_high", busy_a, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_busy_low", busy_a, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_pulses", pulse_cnt - p0, 0);
        chk("glitch_cmd", cmd_a, 8'hFF);

        // ---- Reset during both a TX byte and an RX byte ----
        n = 0;
        while (tx_a !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rst_tx_active", tx_a, 0);
        data_a = 16'h5AC3;
        @(posedge clk);
        #1;
        rx_line = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_rx_active", busy_a, 1);
        p0 = pulse_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx_line = 1'b1;
        r2 = cyc;
        chk("rst_tx", tx_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_cmd", cmd_a, 8'h00);
        chk("rst_pulse", pulse_a, 0);
        wait_start(1'b0, r2 + 200, "rst_restart");
        check_byte(1'b0, 8'h5A, "rst_byte0");
        check_byte(1'b0, 8'hC3, "rst_byte1");
        chk("rst_no_pulse", pulse_cnt - p0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
